ebr_arbiter: RTL

Two-requester scheduler for a single 256x16 EBR_B block RAM. It sits between two client engines (A and B) and the EBR's independent read and write ports. Each cycle it grants at most one read and one write. A read and a write from different requesters proceed in the same cycle. Same-type contention is resolved round-robin, and read responses return with fixed latency.

---
 rtl/ebr_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ebr_arbiter.sv
// Two-requester read/write scheduler in front of a 256x16 EBR_B block RAM.
// Define EBR_ARB_RAW_STALL_EN to stall a read that collides with a granted write.
module ebr_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [DATA_W-1:0] a_mask_n,
    output logic              a_ready,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_valid,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic [DATA_W-1:0] b_mask_n,
    output logic              b_ready,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [10:0]       ebr_raddr,
    output logic [10:0]       ebr_waddr,
    output logic [DATA_W-1:0] ebr_wdata,
    output logic [DATA_W-1:0] ebr_mask_n,
    output logic              ebr_re,
    output logic              ebr_rclke,
    output logic              ebr_we,
    output logic              ebr_wclke,
    input  logic [DATA_W-1:0] ebr_rdata
);

    typedef enum logic {SEL_A = 1'b0, SEL_B = 1'b1} sel_t;

    sel_t rd_ptr;
    sel_t wr_ptr;
    logic a_own;
    logic b_own;

    logic a_rd_req, b_rd_req, a_wr_req, b_wr_req;
    logic a_rd_cand, b_rd_cand;
    logic a_rd_gnt, b_rd_gnt, a_wr_gnt, b_wr_gnt;
    logic wr_gnt;
    logic [ADDR_W-1:0] wr_addr;

    always_comb begin
        a_rd_req = a_valid & ~a_we & ~rst;
        b_rd_req = b_valid & ~b_we & ~rst;
        a_wr_req = a_valid &  a_we & ~rst;
        b_wr_req = b_valid &  b_we & ~rst;

        a_wr_gnt = a_wr_req & (~b_wr_req | (wr_ptr == SEL_A));
        b_wr_gnt = b_wr_req & (~a_wr_req | (wr_ptr == SEL_B));
        wr_gnt   = a_wr_gnt | b_wr_gnt;
        wr_addr  = a_wr_gnt ? a_addr : b_addr;

`ifdef EBR_ARB_RAW_STALL_EN
        // A read hitting the address being written this cycle sits out so it sees the new data.
        a_rd_cand = a_rd_req & ~(wr_gnt & (wr_addr == a_addr));
        b_rd_cand = b_rd_req & ~(wr_gnt & (wr_addr == b_addr));
`else
        a_rd_cand = a_rd_req;
        b_rd_cand = b_rd_req;
`endif

        a_rd_gnt = a_rd_cand & (~b_rd_cand | (rd_ptr == SEL_A));
        b_rd_gnt = b_rd_cand & (~a_rd_cand | (rd_ptr == SEL_B));

        a_ready = a_rd_gnt | a_wr_gnt;
        b_ready = b_rd_gnt | b_wr_gnt;
    end

    always_comb begin
        ebr_raddr  = '0;
        ebr_waddr  = '0;
        ebr_wdata  = '0;
        ebr_mask_n = '0;
        ebr_re     = a_rd_gnt | b_rd_gnt;
        ebr_we     = wr_gnt;
        if (a_rd_gnt) begin
            ebr_raddr[ADDR_W-1:0] = a_addr;
        end else if (b_rd_gnt) begin
            ebr_raddr[ADDR_W-1:0] = b_addr;
        end
        if (a_wr_gnt) begin
            ebr_waddr[ADDR_W-1:0] = a_addr;
            ebr_wdata             = a_wdata;
            ebr_mask_n            = a_mask_n;
        end else if (b_wr_gnt) begin
            ebr_waddr[ADDR_W-1:0] = b_addr;
            ebr_wdata             = b_wdata;
            ebr_mask_n            = b_mask_n;
        end
        ebr_rclke = ebr_re;
        ebr_wclke = ebr_we;
    end

    // Pointer moves to the loser only when both requesters competed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= SEL_A;
            wr_ptr <= SEL_A;
            a_own  <= 1'b0;
            b_own  <= 1'b0;
        end else begin
            if (a_rd_cand & b_rd_cand) begin
                rd_ptr <= a_rd_gnt ? SEL_B : SEL_A;
            end
            if (a_wr_req & b_wr_req) begin
                wr_ptr <= a_wr_gnt ? SEL_B : SEL_A;
            end
            a_own <= a_rd_gnt;
            b_own <= b_rd_gnt;
        end
    end

    always_comb begin
        a_rvalid = a_own;
        b_rvalid = b_own;
        a_rdata  = a_own ? ebr_rdata : '0;
        b_rdata  = b_own ? ebr_rdata : '0;
    end

endmodule
